// File: rtl/jtopl_timer_ctrl.sv
// CPU-side register front end for the OPL timer pair, plus status read and write-busy window.
// Latency: register updates and busy rise one clk after an accepted write; dout is combinational.
// Backpressure: writes arriving while busy is high are dropped; busy lasts ADDR_WAIT/DATA_WAIT cen ticks.
// Optional CSM key-on support is built when JTOPL_CSM_EN is defined.
module jtopl_timer_ctrl #(
  parameter int ADDR_WAIT = 4,
  parameter int DATA_WAIT = 24
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cen,
  input  logic       cs_n,
  input  logic       wr_n,
  input  logic       addr,
  input  logic [7:0] din,
  output logic [7:0] dout,
  output logic       busy,
  output logic [7:0] value_A,
  output logic [7:0] value_B,
  output logic       load_A,
  output logic       load_B,
  output logic       flagen_A,
  output logic       flagen_B,
  output logic       clr_flag_A,
  output logic       clr_flag_B,
  input  logic       flag_A,
  input  logic       flag_B,
  input  logic       overflow_A,
  input  logic       irq_n,
  output logic       csm_kon
);

  localparam int MAX_WAIT = (ADDR_WAIT > DATA_WAIT) ? ADDR_WAIT : DATA_WAIT;
  localparam int CW       = $clog2(MAX_WAIT + 1);

  // Register addresses decoded on the data port
  localparam logic [7:0] REG_TA   = 8'h02;
  localparam logic [7:0] REG_TB   = 8'h03;
  localparam logic [7:0] REG_CTRL = 8'h04;
  localparam logic [7:0] REG_CSM  = 8'h08;

  logic [CW-1:0] r_cnt;
  logic [7:0]    r_areg;
  logic [7:0]    r_value_A;
  logic [7:0]    r_value_B;
  logic          r_load_A;
  logic          r_load_B;
  logic          r_flagen_A;
  logic          r_flagen_B;
  logic          r_clr_A;
  logic          r_clr_B;

  logic w_wr;
  logic w_busy;
  logic w_accept;
  logic w_acc_addr;
  logic w_acc_data;

  // A bus write is a single-clk cs_n/wr_n low; it only counts when the busy window is closed
  assign w_wr       = ~cs_n & ~wr_n;
  assign w_busy     = (r_cnt != '0);
  assign w_accept   = w_wr & ~w_busy;
  assign w_acc_addr = w_accept & ~addr;
  assign w_acc_data = w_accept &  addr;

  // Busy counter: loaded on accept, counts down on cen, saturates at zero
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (w_acc_addr) begin
      r_cnt <= CW'(ADDR_WAIT);
    end else if (w_acc_data) begin
      r_cnt <= CW'(DATA_WAIT);
    end else if (cen && w_busy) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  // Address latch: selects which register the next data write targets
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_areg <= 8'h00;
    end else if (w_acc_addr) begin
      r_areg <= din;
    end
  end

  // Timer registers and control bits written through the data port
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_value_A  <= 8'h00;
      r_value_B  <= 8'h00;
      r_load_A   <= 1'b0;
      r_load_B   <= 1'b0;
      r_flagen_A <= 1'b1;
      r_flagen_B <= 1'b1;
      r_clr_A    <= 1'b0;
      r_clr_B    <= 1'b0;
    end else begin
      // Clear strobes are single-clk pulses
      r_clr_A <= 1'b0;
      r_clr_B <= 1'b0;
      if (w_acc_data) begin
        case (r_areg)
          REG_TA: r_value_A <= din;
          REG_TB: r_value_B <= din;
          REG_CTRL: begin
            if (din[7]) begin
              // IRQ reset: only clears flags, leaves run/mask state alone
              r_clr_A <= 1'b1;
              r_clr_B <= 1'b1;
            end else begin
              // Rewriting a start bit of 1 keeps a running timer running (no reload edge)
              r_load_A   <= din[0];
              r_load_B   <= din[1];
              r_flagen_A <= ~din[6];
              r_flagen_B <= ~din[5];
            end
          end
          default: ;
        endcase
      end
    end
  end

`ifdef JTOPL_CSM_EN
  logic r_csm;
  logic r_ovA_d;
  logic r_kon;

  // CSM mode bit and key-on pulse on each timer A overflow rising edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_csm   <= 1'b0;
      r_ovA_d <= 1'b0;
      r_kon   <= 1'b0;
    end else begin
      r_ovA_d <= overflow_A;
      r_kon   <= r_csm & overflow_A & ~r_ovA_d;
      if (w_acc_data && r_areg == REG_CSM) begin
        r_csm <= din[7];
      end
    end
  end

  assign csm_kon = r_kon;
`else
  // Without CSM the overflow input has no consumer and no state is built
  logic w_unused_csm;
  assign w_unused_csm = overflow_A ^ (REG_CSM == 8'h00);
  assign csm_kon      = 1'b0;
`endif

  assign busy       = w_busy;
  assign value_A    = r_value_A;
  assign value_B    = r_value_B;
  assign load_A     = r_load_A;
  assign load_B     = r_load_B;
  assign flagen_A   = r_flagen_A;
  assign flagen_B   = r_flagen_B;
  assign clr_flag_A = r_clr_A;
  assign clr_flag_B = r_clr_B;

  // Status byte is readable at any time, regardless of chip select
  assign dout = {~irq_n, flag_A, flag_B, 5'b0};

endmodule

// File: tb/tb_jtopl_timer_ctrl.sv
// Directed bench for jtopl_timer_ctrl: register writes, busy window, dropped writes,
// status byte and CSM key-on. Inputs change on the falling edge; outputs are sampled there too.
module tb_jtopl_timer_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cen = 1'b0;
  logic       cs_n = 1'b1;
  logic       wr_n = 1'b1;
  logic       addr = 1'b0;
  logic [7:0] din = 8'h00;
  logic [7:0] dout;
  logic       busy;
  logic [7:0] value_A, value_B;
  logic       load_A, load_B, flagen_A, flagen_B;
  logic       clr_flag_A, clr_flag_B;
  logic       flag_A = 1'b0;
  logic       flag_B = 1'b0;
  logic       overflow_A = 1'b0;
  logic       irq_n = 1'b1;
  logic       csm_kon;

  int n_cmp = 0;
  int n_bad = 0;

  jtopl_timer_ctrl #(.ADDR_WAIT(4), .DATA_WAIT(24)) dut (
    .clk(clk), .rst_n(rst_n), .cen(cen), .cs_n(cs_n), .wr_n(wr_n),
    .addr(addr), .din(din), .dout(dout), .busy(busy),
    .value_A(value_A), .value_B(value_B), .load_A(load_A), .load_B(load_B),
    .flagen_A(flagen_A), .flagen_B(flagen_B),
    .clr_flag_A(clr_flag_A), .clr_flag_B(clr_flag_B),
    .flag_A(flag_A), .flag_B(flag_B), .overflow_A(overflow_A),
    .irq_n(irq_n), .csm_kon(csm_kon)
  );

  always #5 clk = ~clk;

  // cen active one clk in three, so busy length in clks differs from length in ticks
  initial begin
    int k = 0;
    forever begin
      @(negedge clk);
      k++;
      cen = (k % 3 == 0);
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // One-clk write strobe; returns on the falling edge after the accepting rising edge
  task automatic bus_write(input logic a, input logic [7:0] d);
    @(negedge clk);
    cs_n = 1'b0; wr_n = 1'b0; addr = a; din = d;
    @(negedge clk);
    cs_n = 1'b1; wr_n = 1'b1;
  endtask

  // Counts cen ticks until busy falls; optionally injects a write at clk index inj
  task automatic count_busy(input int inj, input logic ia, input logic [7:0] id,
                            output int ticks);
    int n = 0;
    ticks = 0;
    while (busy && n < 300) begin
      if (n == inj) begin
        cs_n = 1'b0; wr_n = 1'b0; addr = ia; din = id;
      end
      @(posedge clk);
      if (cen) ticks++;
      @(negedge clk);
      cs_n = 1'b1; wr_n = 1'b1;
      n++;
    end
    if (n >= 300) check_eq("busy_timeout", 32'd1, 32'd0);
  endtask

  initial begin
    int t;
    int kon;
    int exp_kon;

    // 1) reset values
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_eq("rst_value_A", value_A, 8'h00);
    check_eq("rst_value_B", value_B, 8'h00);
    check_eq("rst_load", {load_A, load_B}, 2'b00);
    check_eq("rst_flagen", {flagen_A, flagen_B}, 2'b11);
    check_eq("rst_clr", {clr_flag_A, clr_flag_B}, 2'b00);
    check_eq("rst_busy", busy, 1'b0);
    check_eq("rst_csm_kon", csm_kon, 1'b0);
    check_eq("rst_dout", dout, 8'h00);

    // 2) timer A value, busy lengths, and a data write dropped while busy
    bus_write(1'b0, 8'h02);
    check_eq("addr_busy_rise", busy, 1'b1);
    count_busy(-1, 1'b0, 8'h00, t);
    check_eq("addr_busy_ticks", t, 4);
    bus_write(1'b1, 8'h9C);
    check_eq("value_A_write", value_A, 8'h9C);
    check_eq("data_busy_rise", busy, 1'b1);
    count_busy(2, 1'b1, 8'h55, t);
    check_eq("data_busy_ticks", t, 24);
    check_eq("value_A_drop", value_A, 8'h9C);

    // 3) address write dropped while busy: areg and busy schedule unchanged
    bus_write(1'b0, 8'h04);
    count_busy(1, 1'b0, 8'h03, t);
    check_eq("addr_drop_ticks", t, 4);

    // 4) control register: load/mask, then IRQ reset pulse
    bus_write(1'b1, 8'h41);
    check_eq("ctrl41_load", {load_A, load_B}, 2'b10);
    check_eq("ctrl41_flagen", {flagen_A, flagen_B}, 2'b01);
    check_eq("ctrl41_value_B", value_B, 8'h00);
    count_busy(-1, 1'b0, 8'h00, t);
    bus_write(1'b1, 8'h80);
    check_eq("clr_pulse", {clr_flag_A, clr_flag_B}, 2'b11);
    check_eq("clr_load_keep", {load_A, load_B}, 2'b10);
    check_eq("clr_flagen_keep", {flagen_A, flagen_B}, 2'b01);
    @(negedge clk);
    check_eq("clr_pulse_end", {clr_flag_A, clr_flag_B}, 2'b00);
    count_busy(-1, 1'b0, 8'h00, t);
    bus_write(1'b1, 8'h23);
    check_eq("ctrl23_load", {load_A, load_B}, 2'b11);
    check_eq("ctrl23_flagen", {flagen_A, flagen_B}, 2'b10);
    check_eq("ctrl23_noclr", {clr_flag_A, clr_flag_B}, 2'b00);
    count_busy(-1, 1'b0, 8'h00, t);

    // timer B value
    bus_write(1'b0, 8'h03);
    count_busy(-1, 1'b0, 8'h00, t);
    bus_write(1'b1, 8'hA5);
    check_eq("value_B_write", value_B, 8'hA5);
    check_eq("value_A_keep", value_A, 8'h9C);
    count_busy(-1, 1'b0, 8'h00, t);

    // 5) status byte
    flag_A = 1'b1; irq_n = 1'b0; #1;
    check_eq("dout_C0", dout, 8'hC0);
    flag_B = 1'b1; #1;
    check_eq("dout_E0", dout, 8'hE0);
    flag_A = 1'b0; irq_n = 1'b1; #1;
    check_eq("dout_20", dout, 8'h20);
    flag_B = 1'b0;

    // 6) CSM: enable, then two overflow rising edges
    bus_write(1'b0, 8'h08);
    count_busy(-1, 1'b0, 8'h00, t);
    bus_write(1'b1, 8'h80);
    count_busy(-1, 1'b0, 8'h00, t);
    kon = 0;
    for (int i = 0; i < 20; i++) begin
      overflow_A = (i >= 3 && i < 6) || (i >= 10 && i < 13);
      @(negedge clk);
      if (csm_kon) kon++;
    end
    overflow_A = 1'b0;
`ifdef JTOPL_CSM_EN
    exp_kon = 2;
`else
    exp_kon = 0;
`endif
    check_eq("csm_kon_pulses", kon, exp_kon);

    // 7) reset in the middle of a busy window
    bus_write(1'b0, 8'h02);
    check_eq("pre_rst_busy", busy, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check_eq("mid_rst_busy", busy, 1'b0);
    check_eq("mid_rst_value_A", value_A, 8'h00);
    check_eq("mid_rst_load", {load_A, load_B}, 2'b00);
    check_eq("mid_rst_flagen", {flagen_A, flagen_B}, 2'b11);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_eq("post_rst_busy", busy, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
